// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   - mem_cmd_e    : MEM-stage command codes
//   - MMIO_*       : byte offsets inside the 16-byte MMIO window
//   - size_e       : access size
//   - wbuf_entry_t : posted-store buffer entry
//   - cmd_size / cmd_signed / cmd_is_load / cmd_is_store / lane_mask
package dmem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_cmd_e;

  localparam logic [3:0] MMIO_TX    = 4'h0;
  localparam logic [3:0] MMIO_HALT  = 4'h4;
  localparam logic [3:0] MMIO_CYCLE = 4'h8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // widx keeps the full 30-bit word index so forwarding never aliases
  typedef struct packed {
    logic        vld;
    logic [29:0] widx;
    logic [3:0]  mask;
    logic [31:0] data;
  } wbuf_entry_t;

  function automatic size_e cmd_size(input logic [3:0] cmd);
    size_e sz;
    case (cmd)
      MEM_LH, MEM_LHU, MEM_SH: sz = SZ_HALF;
      MEM_LW, MEM_SW:          sz = SZ_WORD;
      default:                 sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  function automatic logic cmd_signed(input logic [3:0] cmd);
    return (cmd == MEM_LB) || (cmd == MEM_LH);
  endfunction

  function automatic logic cmd_is_load(input logic [3:0] cmd);
    return (cmd == MEM_LB) || (cmd == MEM_LH) || (cmd == MEM_LW) ||
           (cmd == MEM_LBU) || (cmd == MEM_LHU);
  endfunction

  function automatic logic cmd_is_store(input logic [3:0] cmd);
    return (cmd == MEM_SB) || (cmd == MEM_SH) || (cmd == MEM_SW);
  endfunction

  // Byte lanes touched by an access of size sz at byte offset off
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0001 << off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry posted-store buffer.
//   An entry captured at one edge drains into the array at the following
//   edge; a new capture on that same edge simply replaces it, so stores
//   never stall and same-word stores land in program order.
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   cap_en, cap_widx, cap_mask, cap_data   store to capture this edge
//   lk_widx                           word index of the current load
//   drain_en, drain_widx, drain_mask, drain_data   array write port
//   fwd_sel, fwd_data                 per-byte forwarding select and data
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_en,
  input  logic [29:0]   cap_widx,
  input  logic [3:0]    cap_mask,
  input  logic [31:0]   cap_data,
  input  logic [29:0]   lk_widx,
  output logic          drain_en,
  output logic [AW-1:0] drain_widx,
  output logic [3:0]    drain_mask,
  output logic [31:0]   drain_data,
  output logic [3:0]    fwd_sel,
  output logic [31:0]   fwd_data
);

  wbuf_entry_t entry_q, entry_d;

  always_comb begin
    entry_d     = entry_q;
    // whatever is held now drains at this edge
    entry_d.vld = 1'b0;
    if (cap_en) begin
      entry_d.vld  = 1'b1;
      entry_d.widx = cap_widx;
      entry_d.mask = cap_mask;
      entry_d.data = cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign drain_en   = entry_q.vld;
  assign drain_widx = entry_q.widx[AW-1:0];
  assign drain_mask = entry_q.mask;
  assign drain_data = entry_q.data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign fwd_sel[gi] = entry_q.vld && (entry_q.widx == lk_widx) && entry_q.mask[gi];
  end

  assign fwd_data = entry_q.data;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with posted stores, load
// forwarding and a 16-byte MMIO window (TX byte, HALT flag, cycle counter).
// Loads are combinational; stores go through dmem_wbuf.
// Optional build macro DM_PERF_CNT_EN: when defined, DM_load_cnt /
// DM_store_cnt count legal accesses; otherwise both read 32'h0.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   MEM_mem_cmd/addr/din             request from the core
//   DM_mem_dout                      load result (extended)
//   DM_err, DM_halt                  sticky status flags
//   DM_tx_data, DM_tx_vld            console byte and 1-cycle strobe
//   DM_load_cnt, DM_store_cnt        access counters
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  MEM_mem_cmd,
  input  logic [31:0] MEM_mem_addr,
  input  logic [31:0] MEM_mem_din,
  output logic [31:0] DM_mem_dout,
  output logic        DM_err,
  output logic        DM_halt,
  output logic [7:0]  DM_tx_data,
  output logic        DM_tx_vld,
  output logic [31:0] DM_load_cnt,
  output logic [31:0] DM_store_cnt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   widx;
  logic [3:0]    off;
  size_e         size;
  logic          sgn, is_ld, is_st, in_mmio, oor, misal, bad, ld_ok, st_ok;
  logic          cap_en;
  logic [3:0]    cap_mask;
  logic [31:0]   cap_data;
  logic          drain_en;
  logic [AW-1:0] drain_widx;
  logic [3:0]    drain_mask;
  logic [31:0]   drain_data;
  logic [3:0]    fwd_sel;
  logic [31:0]   fwd_data;
  logic [31:0]   rd_word, merged, raw, shifted, ext;

  logic [31:0] cyc_q, cyc_d;
  logic        err_q, err_d, halt_q, halt_d, tx_vld_q, tx_vld_d;
  logic [7:0]  tx_data_q, tx_data_d;

  assign widx = MEM_mem_addr[31:2];
  assign off  = MEM_mem_addr[3:0];

  // Request decode and legality
  always_comb begin
    size    = cmd_size(MEM_mem_cmd);
    sgn     = cmd_signed(MEM_mem_cmd);
    is_ld   = cmd_is_load(MEM_mem_cmd);
    is_st   = cmd_is_store(MEM_mem_cmd);
    in_mmio = (MEM_mem_addr[31:4] == MMIO_BASE[31:4]);
    oor     = !in_mmio && ({2'b00, widx} >= 32'(DEPTH_WORDS));
    misal   = ((size == SZ_HALF) && MEM_mem_addr[0]) ||
              ((size == SZ_WORD) && (MEM_mem_addr[1:0] != 2'b00));
    bad     = (is_ld || is_st) && (misal || oor);
    ld_ok   = is_ld && !bad;
    st_ok   = is_st && !bad;
  end

  assign cap_en   = st_ok && !in_mmio;
  assign cap_mask = lane_mask(size, MEM_mem_addr[1:0]);
  assign cap_data = MEM_mem_din << {MEM_mem_addr[1:0], 3'b000};

  dmem_wbuf #(.AW(AW)) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en     (cap_en),
    .cap_widx   (widx),
    .cap_mask   (cap_mask),
    .cap_data   (cap_data),
    .lk_widx    (widx),
    .drain_en   (drain_en),
    .drain_widx (drain_widx),
    .drain_mask (drain_mask),
    .drain_data (drain_data),
    .fwd_sel    (fwd_sel),
    .fwd_data   (fwd_data)
  );

  // Array: byte-enabled write from the buffer drain, asynchronous read
  always_ff @(posedge clk) begin
    if (drain_en) begin
      for (int b = 0; b < 4; b++) begin
        if (drain_mask[b]) mem[drain_widx][8*b +: 8] <= drain_data[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[widx[AW-1:0]];

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi +: 8] = fwd_sel[gi] ? fwd_data[8*gi +: 8] : rd_word[8*gi +: 8];
  end

  // Lane select and extension; MMIO words share the same path
  always_comb begin
    if (in_mmio) raw = (off == MMIO_CYCLE) ? cyc_q : 32'h0;
    else         raw = merged;
    shifted = raw >> {MEM_mem_addr[1:0], 3'b000};
    case (size)
      SZ_BYTE: ext = sgn ? {{24{shifted[7]}}, shifted[7:0]}  : {24'h0, shifted[7:0]};
      SZ_HALF: ext = sgn ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign DM_mem_dout = ld_ok ? ext : 32'h0;

  always_comb begin
    cyc_d     = cyc_q + 32'd1;
    err_d     = err_q | bad;
    halt_d    = halt_q | (st_ok && in_mmio && (off == MMIO_HALT));
    tx_vld_d  = st_ok && in_mmio && (off == MMIO_TX) &&
                ((MEM_mem_cmd == MEM_SB) || (MEM_mem_cmd == MEM_SW));
    tx_data_d = tx_vld_d ? MEM_mem_din[7:0] : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q     <= '0;
      err_q     <= 1'b0;
      halt_q    <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      err_q     <= err_d;
      halt_q    <= halt_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign DM_err     = err_q;
  assign DM_halt    = halt_q;
  assign DM_tx_vld  = tx_vld_q;
  assign DM_tx_data = tx_data_q;

`ifdef DM_PERF_CNT_EN
  logic [31:0] load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q  + (ld_ok ? 32'd1 : 32'd0);
    store_cnt_d = store_cnt_q + (st_ok ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign DM_load_cnt  = load_cnt_q;
  assign DM_store_cnt = store_cnt_q;
`else
  assign DM_load_cnt  = 32'h0;
  assign DM_store_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cmd = 4'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] DM_mem_dout, DM_load_cnt, DM_store_cnt;
  logic        DM_err, DM_halt, DM_tx_vld;
  logic [7:0]  DM_tx_data;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MEM_mem_cmd  (cmd),
    .MEM_mem_addr (addr),
    .MEM_mem_din  (din),
    .DM_mem_dout  (DM_mem_dout),
    .DM_err       (DM_err),
    .DM_halt      (DM_halt),
    .DM_tx_data   (DM_tx_data),
    .DM_tx_vld    (DM_tx_vld),
    .DM_load_cnt  (DM_load_cnt),
    .DM_store_cnt (DM_store_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model: a store is visible to later loads immediately;
  // only the store accepted just before a reset is lost.
  logic [7:0]  m_mem [logic [31:0]];
  logic [31:0] m_cyc = 0, m_ld_cnt = 0, m_st_cnt = 0;
  logic        m_err = 0, m_halt = 0, m_tx_vld = 0;
  logic [7:0]  m_tx_data = 0;
  logic [31:0] undo_addr[$];
  logic [7:0]  undo_byte[$];
  logic [31:0] exp_dout = 0;
  logic [3:0]  cur_c = 0;
  logic [31:0] cur_a = 0, cur_d = 0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [3:0] c);
    case (c)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [3:0] c);
    return (c == MEM_LB) || (c == MEM_LH) || (c == MEM_LW) || (c == MEM_LBU) || (c == MEM_LHU);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic bit legal(input logic [3:0] c, input logic [31:0] a);
    int n = nbytes(c);
    if (n == 0) return 0;
    if ((a % n) != 0) return 0;
    return is_mmio(a) || ((a >> 2) < DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] c, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = nbytes(c);
    if (!is_load(c) || !legal(c, a)) return 32'h0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      int lane = int'(a[1:0]) + i;
      if (is_mmio(a)) b = (a[3:0] == 4'h8) ? 8'(m_cyc >> (8 * lane)) : 8'h00;
      else            b = m_mem.exists(a + 32'(i)) ? m_mem[a + 32'(i)] : 8'h00;
      v = v | (32'(b) << (8 * i));
    end
    if (c == MEM_LB) v = {{24{v[7]}}, v[7:0]};
    if (c == MEM_LH) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic step_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    int n = nbytes(c);
    m_cyc++;
    m_tx_vld = 0;
    undo_addr.delete();
    undo_byte.delete();
    if (n != 0) begin
      if (!legal(c, a)) m_err = 1;
      else if (is_load(c)) m_ld_cnt++;
      else begin
        m_st_cnt++;
        if (is_mmio(a)) begin
          if (a[3:0] == 4'h0 && (c == MEM_SB || c == MEM_SW)) begin
            m_tx_data = d[7:0];
            m_tx_vld  = 1;
          end
          if (a[3:0] == 4'h4) m_halt = 1;
        end else begin
          for (int i = 0; i < n; i++) begin
            undo_addr.push_back(a + 32'(i));
            undo_byte.push_back(m_mem.exists(a + 32'(i)) ? m_mem[a + 32'(i)] : 8'h00);
            m_mem[a + 32'(i)] = 8'(d >> (8 * i));
          end
        end
      end
    end
  endtask

  task automatic present(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    cmd = c; addr = a; din = d;
    cur_c = c; cur_a = a; cur_d = d;
    exp_dout = model_load(c, a);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (cur_c != MEM_NONE)
      $display("txn cmd=%0d addr=%08h din=%08h dout=%08h", cur_c, cur_a, cur_d, exp_dout);
    if (rst_n) step_model(cur_c, cur_a, cur_d);
  endtask

  task automatic cycle(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    present(c, a, d);
    advance();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(MEM_NONE, 32'h0, 32'h0);
  endtask

  // Called at posedge+1: asserts reset before the next (drain) edge
  task automatic do_reset();
    logic [31:0] ua;
    present(MEM_NONE, 32'h0, 32'h0);
    rst_n = 1'b0;
    while (undo_addr.size() > 0) begin
      ua = undo_addr.pop_back();
      m_mem[ua] = undo_byte.pop_back();
    end
    m_cyc = 0; m_ld_cnt = 0; m_st_cnt = 0;
    m_err = 0; m_halt = 0; m_tx_vld = 0; m_tx_data = 0;
    #2;
    chk("rst_err", {31'b0, DM_err}, 32'h0);
    chk("rst_halt", {31'b0, DM_halt}, 32'h0);
    chk("rst_txd", {24'b0, DM_tx_data}, 32'h0);
    chk("rst_ldcnt", DM_load_cnt, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", DM_mem_dout, exp_dout);
      chk("err", {31'b0, DM_err}, {31'b0, m_err});
      chk("halt", {31'b0, DM_halt}, {31'b0, m_halt});
      chk("tx_vld", {31'b0, DM_tx_vld}, {31'b0, m_tx_vld});
      chk("tx_data", {24'b0, DM_tx_data}, {24'b0, m_tx_data});
`ifdef DM_PERF_CNT_EN
      chk("load_cnt", DM_load_cnt, m_ld_cnt);
      chk("store_cnt", DM_store_cnt, m_st_cnt);
`else
      chk("load_cnt", DM_load_cnt, 32'h0);
      chk("store_cnt", DM_store_cnt, 32'h0);
`endif
    end
  end

  initial begin
    logic [31:0] t0, t1, a, d;
    logic [3:0]  c;
    int r, n;

    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Give every word that is later read a defined value
    for (int w = 0; w < 64; w++) cycle(MEM_SW, 32'(w * 4), 32'h0);
    cycle(MEM_SW, 32'h3000, 32'h0);
    cycle(MEM_SW, 32'h1000, 32'h0);
    idle(1);

    // Forwarding from the buffered store
    cycle(MEM_SW, 32'h1000, 32'hDEADBEEF);
    present(MEM_LW, 32'h1000, 32'h0);  #2; chk("lw_fwd", DM_mem_dout, 32'hDEADBEEF); advance();
    present(MEM_LB, 32'h1003, 32'h0);  #2; chk("lb_sext", DM_mem_dout, 32'hFFFFFFDE); advance();
    present(MEM_LBU, 32'h1003, 32'h0); #2; chk("lbu_zext", DM_mem_dout, 32'h000000DE); advance();

    // Back-to-back stores to one word
    cycle(MEM_SW, 32'h2000, 32'h11223344);
    cycle(MEM_SB, 32'h2001, 32'h000000AA);
    present(MEM_LW, 32'h2000, 32'h0); #2; chk("b2b_buf", DM_mem_dout, 32'h1122AA44); advance();
    idle(3);
    present(MEM_LW, 32'h2000, 32'h0); #2; chk("b2b_arr", DM_mem_dout, 32'h1122AA44); advance();

    // MMIO
    cycle(MEM_SB, BASE, 32'h00000041);
    chk("tx_data_41", {24'b0, DM_tx_data}, 32'h41);
    chk("tx_vld_hi", {31'b0, DM_tx_vld}, 32'h1);
    idle(1);
    chk("tx_vld_lo", {31'b0, DM_tx_vld}, 32'h0);
    cycle(MEM_SW, BASE + 32'h4, 32'h1);
    chk("halt_set", {31'b0, DM_halt}, 32'h1);
    idle(2);
    chk("halt_sticky", {31'b0, DM_halt}, 32'h1);
    present(MEM_LW, BASE + 32'h8, 32'h0); #2; t0 = DM_mem_dout; advance();
    idle(4);
    present(MEM_LW, BASE + 32'h8, 32'h0); #2; t1 = DM_mem_dout; advance();
    chk("cyc_delta", t1 - t0, 32'd5);

    // Errors
    present(MEM_LH, 32'h1001, 32'h0); #2; chk("misal_dout", DM_mem_dout, 32'h0); advance();
    chk("err_set", {31'b0, DM_err}, 32'h1);
    cycle(MEM_SW, 32'h1002, 32'h12345678);
    chk("err_sticky", {31'b0, DM_err}, 32'h1);
    present(MEM_LW, 32'h1000, 32'h0); #2; chk("misal_st_drop", DM_mem_dout, 32'hDEADBEEF); advance();
    cycle(MEM_SW, 32'h0001_0000, 32'h55555555);

    // Reset before the drain edge discards the buffered store
    cycle(MEM_SW, 32'h3000, 32'hCAFEF00D);
    do_reset();
    present(MEM_LW, 32'h3000, 32'h0); #2; chk("rst_discard", DM_mem_dout, 32'h0); advance();

    // Counter scenario from a clean reset: 3 loads, 1 legal + 1 illegal store
    do_reset();
    cycle(MEM_LW, 32'h0, 32'h0);
    cycle(MEM_LBU, 32'h1, 32'h0);
    cycle(MEM_LW, BASE + 32'h8, 32'h0);
    cycle(MEM_SW, 32'h10, 32'h01020304);
    cycle(MEM_SH, 32'h11, 32'h0000BEEF);
`ifdef DM_PERF_CNT_EN
    chk("ld_cnt_3", DM_load_cnt, 32'd3);
    chk("st_cnt_1", DM_store_cnt, 32'd1);
`else
    chk("ld_cnt_off", DM_load_cnt, 32'd0);
    chk("st_cnt_off", DM_store_cnt, 32'd0);
`endif

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      c = 4'($urandom_range(0, 8));
      n = nbytes(c);
      if (n == 0) n = 1;
      r = $urandom_range(0, 99);
      if (r < 80)      a = 32'($urandom_range(0, 255));
      else if (r < 92) a = BASE + 32'($urandom_range(0, 15));
      else             a = 32'h0001_0000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) != 0) a = a & ~32'(n - 1);
      d = $urandom;
      cycle(c, a, d);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
